// File: rtl/code.sv
// Registered WIDTH-bit adder with carry-in and carry-out.
// Two-level carry lookahead over GROUP-bit blocks feeding a single output register.
module code #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH:0]   sum,
    output logic             out_valid
);

    localparam int NG = WIDTH / GROUP;

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] c;
    logic [NG-1:0]    gg;
    logic [NG-1:0]    gp;
    logic [NG:0]      gc;
    logic [WIDTH:0]   sum_next;

    // Per-bit generate/propagate and group-level generate/propagate.
    always_comb begin : blk_group
        logic t;
        g  = a & b;
        p  = a ^ b;
        gg = '0;
        gp = '0;
        for (int k = 0; k < NG; k++) begin
            gp[k] = &p[k*GROUP +: GROUP];
            for (int j = 0; j < GROUP; j++) begin
                t = g[k*GROUP + j];
                for (int m = j + 1; m < GROUP; m++) begin
                    t = t & p[k*GROUP + m];
                end
                gg[k] = gg[k] | t;
            end
        end
    end

    // Second level: every group carry-in is a flat sum of products of cin and group G/P.
    always_comb begin : blk_lookahead
        logic t;
        gc = '0;
        for (int k = 0; k <= NG; k++) begin
            t = cin;
            for (int m = 0; m < k; m++) begin
                t = t & gp[m];
            end
            gc[k] = t;
            for (int j = 0; j < k; j++) begin
                t = gg[j];
                for (int m = j + 1; m < k; m++) begin
                    t = t & gp[m];
                end
                gc[k] = gc[k] | t;
            end
        end
    end

    // Carries inside each block, expanded from that block's carry-in.
    always_comb begin : blk_carry
        logic t;
        c = '0;
        for (int k = 0; k < NG; k++) begin
            for (int i = 0; i < GROUP; i++) begin
                t = gc[k];
                for (int m = 0; m < i; m++) begin
                    t = t & p[k*GROUP + m];
                end
                c[k*GROUP + i] = t;
                for (int j = 0; j < i; j++) begin
                    t = g[k*GROUP + j];
                    for (int m = j + 1; m < i; m++) begin
                        t = t & p[k*GROUP + m];
                    end
                    c[k*GROUP + i] = c[k*GROUP + i] | t;
                end
            end
        end
    end

    assign sum_next = {gc[NG], p ^ c};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum       <= '0;
            out_valid <= 1'b0;
        end else if (in_valid) begin
            sum       <= sum_next;
            out_valid <= 1'b1;
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_code.sv
// Directed and random checks of the registered lookahead adder against a+b+cin.
module tb_code;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [16:0] sum;
    logic        out_valid;

    int n_checks = 0;
    int n_pass   = 0;

    code #(.WIDTH(16), .GROUP(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sum       (sum),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Drive on the falling edge, then sample just after the next rising edge.
    task automatic step(input logic rn, input logic iv, input logic [15:0] av,
                        input logic [15:0] bv, input logic cv);
        @(negedge clk);
        rst_n    = rn;
        in_valid = iv;
        a        = av;
        b        = bv;
        cin      = cv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [16:0] exp_sum;
        logic        iv;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;

        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
            check("rst_sum", sum, 17'h00000);
            check("rst_valid", out_valid, 1'b0);
        end

        step(1'b1, 1'b1, 16'h40C5, 16'hF0F0, 1'b0);
        check("mixed_sum", sum, 17'h131B5);
        check("mixed_valid", out_valid, 1'b1);

        step(1'b1, 1'b1, 16'hFFFF, 16'h0000, 1'b1);
        check("chain_sum", sum, 17'h10000);
        step(1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
        check("max_sum", sum, 17'h1FFFF);
        check("max_valid", out_valid, 1'b1);

        step(1'b1, 1'b1, 16'h1234, 16'h1111, 1'b1);
        check("b2b0_sum", sum, 17'h02346);
        check("b2b0_valid", out_valid, 1'b1);
        step(1'b1, 1'b1, 16'h0000, 16'h0000, 1'b0);
        check("b2b1_sum", sum, 17'h00000);
        check("b2b1_valid", out_valid, 1'b1);
        step(1'b1, 1'b0, 16'hAAAA, 16'h5555, 1'b1);
        check("idle_sum", sum, 17'h00000);
        check("idle_valid", out_valid, 1'b0);

        step(1'b1, 1'b1, 16'h8000, 16'h8000, 1'b0);
        check("pre_rst_sum", sum, 17'h10000);
        check("pre_rst_valid", out_valid, 1'b1);
        step(1'b0, 1'b1, 16'h1234, 16'h4321, 1'b1);
        check("mid_rst_sum", sum, 17'h00000);
        check("mid_rst_valid", out_valid, 1'b0);

        exp_sum = 17'h00000;
        for (int i = 0; i < 10000; i++) begin
            iv = 1'($urandom_range(0, 1));
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom_range(0, 1));
            step(1'b1, iv, ra, rb, rc);
            if (iv) exp_sum = {1'b0, ra} + {1'b0, rb} + {16'b0, rc};
            check("rand_sum", sum, exp_sum);
            check("rand_valid", out_valid, iv);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
